alu_share_arbiter: RTL and testbench

- Shares a single ALUConFlags instance (32-bit A/B, 2-bit ALUControl, 32-bit result, 4-bit ALUFlags) between two requesters, e.g. the core datapath and an address/compare unit.
- Arbitrates round-robin with valid/ready handshakes and registers the operands.
- Returns a registered result, flags and requester ID.
- Keeps an architectural flags register, updated only by operations that request it.

---
 rtl/alu_share_arbiter.sv | 165 ++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one ADD/SUB/AND/OR ALU between two requesters.
// Requests are arbitrated round-robin and their operands are registered.
// Each result is held in a response register until the consumer accepts it.
// An architectural NZCV register is updated only by operations that set
// their setflags bit.
module alu_share_arbiter #(
    parameter int   WIDTH   = 32,
    parameter logic RR_INIT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [1:0]       ctrl0,
    input  logic [1:0]       ctrl1,
    input  logic             setflags0,
    input  logic             setflags1,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags,
    output logic [3:0]       arch_flags,
    output logic             busy
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t           state;
    state_t           next_state;
    logic             rr_ptr;
    logic [1:0]       grant;
    logic             grant_id;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [1:0]       op_ctrl;
    logic             op_setflags;
    logic             op_id;

    logic [WIDTH-1:0] b_eff;
    logic             carry_in;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_result;
    logic [3:0]       alu_flags;

    // Arbitration and sequencing. A lone valid requester wins outright;
    // under contention the requester named by rr_ptr wins.
    always_comb begin
        next_state = state;
        grant      = 2'b00;
        case (state)
            IDLE: begin
                case (req_valid)
                    2'b01:   grant = 2'b01;
                    2'b10:   grant = 2'b10;
                    2'b11:   grant = rr_ptr ? 2'b10 : 2'b01;
                    default: grant = 2'b00;
                endcase
                if (grant != 2'b00) begin
                    next_state = EXEC;
                end
            end
            EXEC: next_state = RESP;
            RESP: begin
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign req_ready = grant;
    assign grant_id  = grant[1];
    assign busy      = (state != IDLE);

    // The ALU: SUB is computed as A + ~B + 1, so the carry out is NOT borrow.
    // Overflow occurs when both addends share a sign that the sum does not.
    always_comb begin
        b_eff      = (op_ctrl == OP_SUB) ? ~op_b : op_b;
        carry_in   = (op_ctrl == OP_SUB);
        sum        = {1'b0, op_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, carry_in};
        alu_result = sum[WIDTH-1:0];
        alu_flags  = 4'b0000;
        case (op_ctrl)
            OP_ADD, OP_SUB: begin
                alu_result   = sum[WIDTH-1:0];
                alu_flags[1] = sum[WIDTH];
                alu_flags[0] = (op_a[WIDTH-1] == b_eff[WIDTH-1]) &&
                               (sum[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_AND: alu_result = op_a & op_b;
            OP_OR:  alu_result = op_a | op_b;
            default: alu_result = sum[WIDTH-1:0];
        endcase
        alu_flags[3] = alu_result[WIDTH-1];
        alu_flags[2] = (alu_result == '0);
    end

    // State register and round-robin pointer. The pointer moves to the
    // loser on every grant, so contending requesters alternate.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            rr_ptr <= RR_INIT;
        end else begin
            state <= next_state;
            if (grant != 2'b00) begin
                rr_ptr <= ~grant_id;
            end
        end
    end

    // Operand capture on grant, then response and flag capture in EXEC.
    // The response is held until the consumer accepts it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_a        <= '0;
            op_b        <= '0;
            op_ctrl     <= 2'b00;
            op_setflags <= 1'b0;
            op_id       <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_id      <= 1'b0;
            rsp_result  <= '0;
            rsp_flags   <= 4'b0000;
            arch_flags  <= 4'b0000;
        end else begin
            if (state == IDLE && grant != 2'b00) begin
                op_a        <= grant_id ? a1 : a0;
                op_b        <= grant_id ? b1 : b0;
                op_ctrl     <= grant_id ? ctrl1 : ctrl0;
                op_setflags <= grant_id ? setflags1 : setflags0;
                op_id       <= grant_id;
            end
            if (state == EXEC) begin
                rsp_valid  <= 1'b1;
                rsp_id     <= op_id;
                rsp_result <= alu_result;
                rsp_flags  <= alu_flags;
                if (op_setflags) begin
                    arch_flags <= alu_flags;
                end
            end
            if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: table-driven single-requester vectors, plus sequences
// for contention, response back-pressure and reset in the middle of an
// operation. Expected responses are queued when requests are driven and
// popped when the DUT completes a response handshake.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] a0, b0, a1, b1;
    logic [1:0]  ctrl0, ctrl1;
    logic        setflags0, setflags1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic [3:0]  arch_flags;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        id;
        logic [31:0] result;
        logic [3:0]  flags;
        logic [3:0]  arch;
    } exp_t;

    typedef struct {
        logic        id;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  ctrl;
        logic        sf;
        logic [31:0] exp_result;
        logic [3:0]  exp_flags;
        logic [3:0]  exp_arch;
    } vec_t;

    exp_t sb[$];
    exp_t popped;
    vec_t vecs[7];

    alu_share_arbiter #(.WIDTH(32), .RR_INIT(1'b0)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .a0         (a0),
        .b0         (b0),
        .a1         (a1),
        .b1         (b1),
        .ctrl0      (ctrl0),
        .ctrl1      (ctrl1),
        .setflags0  (setflags0),
        .setflags1  (setflags1),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .arch_flags (arch_flags),
        .busy       (busy)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    // Independent ALU reference using wide signed/unsigned arithmetic.
    function automatic exp_t model(input logic id, input logic [31:0] a, input logic [31:0] b,
                                   input logic [1:0] ctrl, input logic [3:0] arch);
        exp_t        e;
        longint      sa;
        longint      sbv;
        longint      swide;
        longint      ua;
        longint      ub;
        logic [31:0] r;
        logic        c;
        logic        v;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ua  = longint'({32'b0, a});
        ub  = longint'({32'b0, b});
        c = 1'b0;
        v = 1'b0;
        case (ctrl)
            2'b00: begin
                r     = a + b;
                c     = ((ua + ub) > 64'sd4294967295);
                swide = sa + sbv;
                v     = (swide > 64'sd2147483647) || (swide < -64'sd2147483648);
            end
            2'b01: begin
                r     = a - b;
                c     = (ua >= ub);
                swide = sa - sbv;
                v     = (swide > 64'sd2147483647) || (swide < -64'sd2147483648);
            end
            2'b10:   r = a & b;
            default: r = a | b;
        endcase
        e.id     = id;
        e.result = r;
        e.flags  = {r[31], (r == 32'h0), c, v};
        e.arch   = arch;
        return e;
    endfunction

    // Scoreboard: compare every accepted response against the queue head.
    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_rsp actual=id%0d required=no response", rsp_id);
            end else begin
                popped = sb.pop_front();
                checkOutput("rsp_id",     32'(rsp_id),     32'(popped.id));
                checkOutput("rsp_result", rsp_result,      popped.result);
                checkOutput("rsp_flags",  32'(rsp_flags),  32'(popped.flags));
                checkOutput("arch_flags", 32'(arch_flags), 32'(popped.arch));
            end
        end
    end

    // At most one requester may ever be granted.
    always @(negedge clk) begin
        if (!reset && req_valid == 2'b11) begin
            checkOutput("ready_onehot", 32'(req_ready == 2'b11), 32'd0);
        end
    end

    task automatic setOps(input logic id, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] ctrl, input logic sf);
        if (id) begin
            a1 = a; b1 = b; ctrl1 = ctrl; setflags1 = sf;
        end else begin
            a0 = a; b0 = b; ctrl0 = ctrl; setflags0 = sf;
        end
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            failures++;
            $display("[TB] FAIL idle_timeout actual=busy required=idle");
        end
    endtask

    task automatic waitGrant(output logic ok);
        int n;
        n = 0;
        @(negedge clk);
        while (req_ready == 2'b00 && n < 10) begin
            @(negedge clk);
            n++;
        end
        ok = (req_ready != 2'b00);
        if (!ok) begin
            checks++;
            failures++;
            $display("[TB] FAIL grant_timeout actual=no grant required=grant");
        end
    endtask

    // One single-requester transaction with latency and handshake checks.
    task automatic applyStimulus(input vec_t v);
        exp_t e;
        @(posedge clk); #1;
        setOps(v.id, v.a, v.b, v.ctrl, v.sf);
        req_valid = v.id ? 2'b10 : 2'b01;
        @(negedge clk);
        checkOutput("req_ready_idle", 32'(req_ready), v.id ? 32'd2 : 32'd1);
        e.id = v.id; e.result = v.exp_result; e.flags = v.exp_flags; e.arch = v.exp_arch;
        sb.push_back(e);
        @(posedge clk); #1;
        req_valid = 2'b00;
        setOps(v.id, 32'hDEADBEEF, 32'h12345678, ~v.ctrl, ~v.sf);
        @(negedge clk);
        checkOutput("exec_ready", 32'(req_ready), 32'd0);
        checkOutput("exec_busy",  32'(busy),      32'd1);
        checkOutput("exec_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        checkOutput("latency_rsp_valid", 32'(rsp_valid), 32'd1);
        waitIdle();
    endtask

    // Both requesters held valid; grants must alternate from requester 0.
    task automatic contention(input int grants);
        logic exp_id;
        logic ok;
        exp_t e;
        exp_id = 1'b0;
        @(posedge clk); #1;
        setOps(1'b0, 32'h91,   32'hE9,   2'b10, 1'b0);
        setOps(1'b1, 32'h4011, 32'h7E89, 2'b11, 1'b0);
        req_valid = 2'b11;
        for (int g = 0; g < grants; g++) begin
            waitGrant(ok);
            if (!ok) break;
            checkOutput("rr_grant", 32'(req_ready), exp_id ? 32'd2 : 32'd1);
            if (g == 0) begin
                e.id = 1'b0; e.result = 32'h81; e.flags = 4'b0000; e.arch = 4'b0000;
            end else if (g == 1) begin
                e.id = 1'b1; e.result = 32'h7E99; e.flags = 4'b0000; e.arch = 4'b0000;
            end else if (exp_id) begin
                e = model(1'b1, a1, b1, ctrl1, 4'b0000);
            end else begin
                e = model(1'b0, a0, b0, ctrl0, 4'b0000);
            end
            sb.push_back(e);
            @(posedge clk); #1;
            setOps(exp_id, $urandom, $urandom, 2'($urandom_range(0, 3)), 1'b0);
            exp_id = ~exp_id;
        end
        req_valid = 2'b00;
        waitIdle();
    endtask

    // Back-pressure: the response must stay frozen while rsp_ready is low.
    task automatic holdTest();
        int   n;
        exp_t e;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        setOps(1'b0, 32'h5, 32'h5, 2'b01, 1'b0);
        req_valid = 2'b01;
        @(negedge clk);
        checkOutput("hold_grant", 32'(req_ready), 32'd1);
        e.id = 1'b0; e.result = 32'h0; e.flags = 4'b0110; e.arch = 4'b1000;
        sb.push_back(e);
        @(posedge clk); #1;
        req_valid = 2'b11;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            checkOutput("hold_rsp_valid",  32'(rsp_valid),  32'd1);
            checkOutput("hold_result",     rsp_result,      32'h0);
            checkOutput("hold_flags",      32'(rsp_flags),  32'h6);
            checkOutput("hold_arch",       32'(arch_flags), 32'h8);
            checkOutput("hold_req_ready",  32'(req_ready),  32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("hold_back_idle", 32'(busy),      32'd0);
        checkOutput("hold_rsp_clear", 32'(rsp_valid), 32'd0);
    endtask

    // Reset while an operation is in EXEC must drop it without a response.
    task automatic resetInExec();
        vec_t v;
        @(posedge clk); #1;
        setOps(1'b1, 32'h1, 32'h1, 2'b00, 1'b1);
        req_valid = 2'b10;
        @(posedge clk); #1;
        req_valid = 2'b00;
        checkOutput("pre_reset_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("rst_exec_rsp_valid", 32'(rsp_valid),  32'd0);
        checkOutput("rst_exec_arch",      32'(arch_flags), 32'd0);
        checkOutput("rst_exec_busy",      32'(busy),       32'd0);
        @(negedge clk);
        checkOutput("rst_exec_held", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        v = '{1'b1, 32'h2, 32'h3, 2'b00, 1'b1, 32'h5, 4'b0000, 4'b0000};
        applyStimulus(v);
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'h00000001, 32'h00000081, 2'b00, 1'b1, 32'h00000082, 4'b0000, 4'b0000};
        vecs[1] = '{1'b1, 32'h00000011, 32'h00000089, 2'b01, 1'b1, 32'hFFFFFF88, 4'b1000, 4'b1000};
        vecs[2] = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 2'b00, 1'b1, 32'h00000000, 4'b0110, 4'b0110};
        vecs[3] = '{1'b1, 32'h7FFFFFFF, 32'h00000001, 2'b00, 1'b0, 32'h80000000, 4'b1001, 4'b0110};
        vecs[4] = '{1'b0, 32'h80000000, 32'h00000001, 2'b01, 1'b1, 32'h7FFFFFFF, 4'b0011, 4'b0011};
        vecs[5] = '{1'b1, 32'hF0F0F0F0, 32'h0F0F0F0F, 2'b10, 1'b1, 32'h00000000, 4'b0100, 4'b0100};
        vecs[6] = '{1'b0, 32'h80000000, 32'h00000001, 2'b11, 1'b1, 32'h80000001, 4'b1000, 4'b1000};

        reset = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        setOps(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        setOps(1'b1, 32'h0, 32'h0, 2'b00, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("reset_rsp_valid",  32'(rsp_valid),  32'd0);
        checkOutput("reset_rsp_id",     32'(rsp_id),     32'd0);
        checkOutput("reset_rsp_result", rsp_result,      32'd0);
        checkOutput("reset_rsp_flags",  32'(rsp_flags),  32'd0);
        checkOutput("reset_arch_flags", 32'(arch_flags), 32'd0);
        checkOutput("reset_req_ready",  32'(req_ready),  32'd0);
        checkOutput("reset_busy",       32'(busy),       32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        contention(6);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i]);
        end
        holdTest();
        resetInExec();

        repeat (2) @(negedge clk);
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
